// File: rtl/rand_source_if.sv
// Draw-request handshake between the game control FSM (master) and rand_source (slave).
interface rand_source_if #(
  parameter int unsigned VAL_W = 4
);
  logic             req;
  logic [VAL_W-1:0] rand_val;
  logic             rand_ready;
  logic             busy;

  modport master (output req, input rand_val, rand_ready, busy);
  modport slave  (input req, output rand_val, rand_ready, busy);
endinterface

// File: rtl/rand_source.sv
// Bounded random-value source: free-running Galois LFSR with rejection sampling and a
// bounded-latency fallback. Optional macro NO_REPEAT_EN rejects a repeat of the last value.
module rand_source #(
  parameter int unsigned          LFSR_W    = 16,
  parameter logic [LFSR_W-1:0]    TAPS      = 16'hB400,
  parameter logic [LFSR_W-1:0]    SEED      = 16'hACE1,
  parameter int unsigned          VAL_W     = 4,
  parameter int unsigned          RANGE     = 10,
  parameter int unsigned          MAX_TRIES = 8
) (
  input  logic         clk,
  input  logic         rst,
  rand_source_if.slave bus
);

  localparam int unsigned        TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TRY_W-1:0]   LAST_TRY = TRY_W'(MAX_TRIES - 1);
  localparam logic [VAL_W:0]     RANGE_X  = RANGE[VAL_W:0];
  localparam logic [VAL_W-1:0]   RANGE_LO = RANGE[VAL_W-1:0];

  typedef enum logic [1:0] {IDLE, DRAW, HOLD} state_e;

  state_e            state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [VAL_W-1:0]  val_q, val_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic [TRY_W-1:0]  tries_q, tries_d;

  logic [VAL_W-1:0]  cand;
  logic [VAL_W-1:0]  fallback;
  logic              in_range;
  logic              repeat_hit;
  logic              accept;
  logic              give_up;

  assign lfsr_d   = (lfsr_q == '0) ? SEED : ((lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0));
  assign cand     = lfsr_q[VAL_W-1:0];
  assign in_range = {1'b0, cand} < RANGE_X;
  // Out-of-range candidates lie in [RANGE, 2**VAL_W), so one subtraction folds them into range.
  assign fallback = in_range ? cand : cand - RANGE_LO;
  assign accept   = in_range && !repeat_hit;
  assign give_up  = (tries_q == LAST_TRY);

`ifdef NO_REPEAT_EN
  logic [VAL_W-1:0] prev_q;
  logic             prev_valid_q;
  logic             deliver;

  assign deliver    = (state_q == DRAW) && bus.req && (accept || give_up);
  assign repeat_hit = prev_valid_q && (cand == prev_q) && (RANGE > 1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
    end else if (deliver) begin
      prev_q       <= val_d;
      prev_valid_q <= 1'b1;
    end
  end
`else
  assign repeat_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    tries_d = tries_q;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          state_d = DRAW;
          busy_d  = 1'b1;
          tries_d = '0;
        end
      end
      DRAW: begin
        if (!bus.req) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (accept || give_up) begin
          // Fallback path skips the repeat check so latency stays bounded.
          val_d   = accept ? cand : fallback;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = HOLD;
        end else begin
          tries_d = tries_q + 1'b1;
        end
      end
      HOLD: begin
        if (!bus.req) begin
          state_d = IDLE;
          ready_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      lfsr_q  <= SEED;
      val_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      tries_q <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      val_q   <= val_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      tries_q <= tries_d;
    end
  end

  assign bus.rand_val   = val_q;
  assign bus.rand_ready = ready_q;
  assign bus.busy       = busy_q;

endmodule
